prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Boot controller upstream of risc_cpu. Streams a program image into the 32x8 program memory
//  over a valid/ready byte interface and holds the CPU in reset while it does so. It then
//  releases the CPU and watches cpu_halt, reporting the halt PC or a watchdog timeout.
//  Lets benches and the board harness load and run programs without preloaded memory files.
// PARAMETERS
//  ADDR_W    5     program memory address width (depth = 2**ADDR_W)
//  DATA_W    8     instruction/data word width
//  RST_HOLD  4     cycles cpu_rst stays high after the last write before release (>=1)
//  TIMEOUT   1023  max RUN cycles before the watchdog fires (>=1)
// PORTS
//  clk         in   1       system clock, rising edge
//  rst         in   1       asynchronous active-high reset
//  load_start  in   1       pulse: begin loading at address 0
//  in_valid    in   1       input byte valid
//  in_ready    out  1       loader accepts a byte (high only in LOAD)
//  in_data     in   DATA_W  program byte
//  in_last     in   1       qualifies the final byte of the image
//  mem_we      out  1       program memory write strobe
//  mem_addr    out  ADDR_W  program memory write address
//  mem_wdata   out  DATA_W  program memory write data
//  cpu_rst     out  1       reset to risc_cpu, active-high
//  cpu_halt    in   1       risc_cpu halt flag
//  cpu_pc      in   ADDR_W  risc_cpu program counter
//  busy        out  1       high in LOAD, HOLD and RUN
//  done        out  1       CPU halted normally; sticky until next load_start
//  timeout     out  1       watchdog fired; sticky until next load_start
//  result_pc   out  ADDR_W  cpu_pc captured on halt
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, cpu_rst=1, mem_we=0, mem_addr=0, mem_wdata=0,
//   done=0, timeout=0, result_pc=0, counters=0. Memory already written is not cleared.
//  FSM states: IDLE, LOAD, HOLD, RUN, DONE, ERR. All outputs are registered except in_ready
//   and busy, which decode the state directly.
//  IDLE: cpu_rst=1. If load_start=1, go to LOAD, set wr_ptr=0, clear done/timeout.
//  LOAD: in_ready=1. On beat (in_valid&in_ready), the next cycle has mem_we=1,
//   mem_addr=wr_ptr, mem_wdata=in_data; then wr_ptr++. mem_we is a single-cycle pulse per beat.
//   The stream may stall: with in_valid=0 there is no write.
//   Go to HOLD on the beat with in_last=1, or on the beat with wr_ptr=2**ADDR_W-1. A full
//   image ends the load: no wrap, and further bytes are not accepted. load_start is ignored.
//  HOLD: cpu_rst=1. Count RST_HOLD cycles, starting with the cycle after the final mem_we,
//   then go to RUN.
//  RUN: cpu_rst=0. run_cnt increments each cycle.
//   cpu_halt=1 -> DONE, result_pc<=cpu_pc, done<=1.
//   Else run_cnt==TIMEOUT-1 -> ERR, timeout<=1.
//   If cpu_halt and watchdog expiry fall on the same cycle, halt wins.
//  DONE: cpu_rst stays 0 so the halted CPU state can be inspected.
//  ERR: cpu_rst<=1.
//  DONE/ERR: load_start=1 -> LOAD, with cpu_rst<=1 the same edge and done/timeout cleared.
//  done and timeout are never high together.
//  Latency: load_start to first in_ready = 1 cycle. The beat-to-mem_we delay is 1 cycle.
//   Last write to cpu_rst falling = RST_HOLD+1 cycles.
// TESTING
//  1 Load 3 bytes (E0,01,1F) with in_last on byte 3 -> mem_we at addr 0,1,2 with the same data;
//    in_ready low after beat 3; cpu_rst falls RST_HOLD+1 cycles after the last write.
//  2 Full program 3 image (LDA/AND/XOR/ADD/SKZ/STO/JMP, HLT at 0x10) -> done=1, result_pc=0x10,
//    timeout=0, cpu_rst=0 in DONE.
//  3 Stream 40 bytes, in_last never set -> exactly 32 writes (addr 0..31); in_ready low after beat 32.
//  4 Image with cpu_halt held low -> timeout=1 exactly TIMEOUT cycles after RUN entry; cpu_rst=1.
//  5 Toggle in_valid every other cycle in LOAD; assert rst mid-LOAD -> correct sparse writes;
//    after reset all outputs match reset values; load_start reloads from addr 0.
//  6 cpu_halt rising on the watchdog expiry cycle -> done=1, timeout=0.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: streams a program image into program memory while holding the CPU in reset,
// then releases the CPU and reports its halt PC or a watchdog timeout.
module prog_loader #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int RST_HOLD = 4,
    parameter int TIMEOUT  = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_last_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              cpu_rst_o,
    input  logic              cpu_halt_i,
    input  logic [ADDR_W-1:0] cpu_pc_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              timeout_o,
    output logic [ADDR_W-1:0] result_pc_o
);
    typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, DONE, ERR} state_t;
    localparam int HW = $clog2(RST_HOLD + 1) + 1;
    localparam int RW = $clog2(TIMEOUT) + 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, mem_addr_q, mem_addr_d, result_pc_q, result_pc_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d, cpu_rst_q, cpu_rst_d;
    logic              done_q, done_d, timeout_q, timeout_d;
    logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
    logic [RW-1:0]     run_cnt_q, run_cnt_d;
    logic              beat;

    assign in_ready_o  = state_q == LOAD;
    assign busy_o      = state_q inside {LOAD, HOLD, RUN};
    assign beat        = in_ready_o && in_valid_i;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign cpu_rst_o   = cpu_rst_q;
    assign done_o      = done_q;
    assign timeout_o   = timeout_q;
    assign result_pc_o = result_pc_q;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rst_d   = cpu_rst_q;
        done_d      = done_q;
        timeout_d   = timeout_q;
        result_pc_d = result_pc_q;
        hold_cnt_d  = hold_cnt_q;
        run_cnt_d   = run_cnt_q;
        case (state_q)
            IDLE, DONE, ERR: if (load_start_i) begin
                state_d   = LOAD;
                wr_ptr_d  = '0;
                cpu_rst_d = 1'b1;
                done_d    = 1'b0;
                timeout_d = 1'b0;
            end
            LOAD: if (beat) begin
                mem_we_d    = 1'b1;
                mem_addr_d  = wr_ptr_q;
                mem_wdata_d = in_data_i;
                wr_ptr_d    = wr_ptr_q + 1'b1;
                hold_cnt_d  = '0;
                // the last address ends the image: no wrap onto already-written code
                if (in_last_i || &wr_ptr_q) state_d = HOLD;
            end
            HOLD: if (hold_cnt_q == HW'(RST_HOLD)) begin
                state_d   = RUN;
                cpu_rst_d = 1'b0;
                run_cnt_d = '0;
            end else begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end
            RUN: begin
                run_cnt_d = run_cnt_q + 1'b1;
                if (cpu_halt_i) begin
                    state_d     = DONE;
                    result_pc_d = cpu_pc_i;
                    done_d      = 1'b1;
                end else if (run_cnt_q == RW'(TIMEOUT - 1)) begin
                    state_d   = ERR;
                    timeout_d = 1'b1;
                    cpu_rst_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rst_q   <= 1'b1;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            result_pc_q <= '0;
            hold_cnt_q  <= '0;
            run_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rst_q   <= cpu_rst_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            result_pc_q <= result_pc_d;
            hold_cnt_q  <= hold_cnt_d;
            run_cnt_q   <= run_cnt_d;
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: random and directed image loads checked every cycle against a timeline model,
// with a stub CPU that halts after a chosen number of run cycles.
module tb_prog_loader;
    localparam int RH = 4, TO = 1023, DEPTH = 32;

    logic       clk = 0, rst = 1, load_start = 0, in_valid = 0, in_last = 0;
    logic [7:0] in_data = 0;
    logic       in_ready, mem_we, cpu_rst, cpu_halt, busy, done, timeout;
    logic [4:0] mem_addr, cpu_pc, result_pc;
    logic [7:0] mem_wdata;

    prog_loader dut (
        .clk(clk), .rst(rst), .load_start_i(load_start), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .in_data_i(in_data), .in_last_i(in_last),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .cpu_rst_o(cpu_rst), .cpu_halt_i(cpu_halt), .cpu_pc_i(cpu_pc),
        .busy_o(busy), .done_o(done), .timeout_o(timeout), .result_pc_o(result_pc)
    );

    always #5 clk = ~clk;

    // stub CPU: pc counts run cycles and freezes once halted
    int rc = 0, halt_at = 0;
    bit halt_en = 0;
    always @(posedge clk) rc <= cpu_rst ? 0 : (cpu_halt ? rc : rc + 1);
    assign cpu_halt = !cpu_rst && halt_en && rc >= halt_at;
    assign cpu_pc   = rc[4:0];

    int n_cmp = 0, n_bad = 0, cyc = 0;
    task automatic chk(input string n, input int a, input int e);
        n_cmp++;
        if (a != e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    // timeline model: a load is a run of accepted bytes; after the final write the CPU is
    // released RH+1 cycles later and watched for halt until TO run cycles have elapsed
    bit m_load = 0, m_active = 0;
    int m_ptr = 0, m_run_at = 0, m_to_at = 0;
    bit e_we = 0, e_rst = 1, e_done = 0, e_to = 0;
    int e_addr = 0, e_wdata = 0, e_pc = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_load = 0; m_active = 0; e_we = 0; e_rst = 1; e_done = 0; e_to = 0;
            e_addr = 0; e_wdata = 0; e_pc = 0;
        end else begin
            cyc++;
            e_we = 0;
            if (m_load) begin
                if (in_valid) begin
                    e_we = 1; e_addr = m_ptr; e_wdata = int'(in_data);
                    if (in_last || m_ptr == DEPTH - 1) begin
                        m_load = 0; m_active = 1; m_run_at = cyc + RH + 1; m_to_at = m_run_at + TO;
                    end
                    m_ptr++;
                end
            end else if (m_active) begin
                if (cyc == m_run_at) e_rst = 0;
                else if (cyc > m_run_at) begin
                    if (cpu_halt) begin
                        e_done = 1; e_pc = int'(cpu_pc); m_active = 0;
                    end else if (cyc == m_to_at) begin
                        e_to = 1; e_rst = 1; m_active = 0;
                    end
                end
            end else if (load_start) begin
                m_load = 1; m_ptr = 0; e_done = 0; e_to = 0; e_rst = 1;
            end
        end
    end

    int wq[$];
    int t_we = 0, t_fall = 0, t_to = 0;
    bit prev_rst = 1, prev_to = 0;
    always @(posedge clk) begin
        #1;
        chk("in_ready", int'(in_ready), int'(m_load));
        chk("busy", int'(busy), int'(m_load || m_active));
        chk("mem_we", int'(mem_we), int'(e_we));
        chk("mem_addr", int'(mem_addr), e_addr);
        chk("mem_wdata", int'(mem_wdata), e_wdata);
        chk("cpu_rst", int'(cpu_rst), int'(e_rst));
        chk("done", int'(done), int'(e_done));
        chk("timeout", int'(timeout), int'(e_to));
        chk("result_pc", int'(result_pc), e_pc);
        chk("done_and_timeout", int'(done && timeout), 0);
        if (mem_we) begin
            wq.push_back(int'({mem_addr, mem_wdata}));
            t_we = cyc;
        end
        if (prev_rst && !cpu_rst) t_fall = cyc;
        if (!prev_to && timeout) t_to = cyc;
        prev_rst = cpu_rst;
        prev_to  = timeout;
    end

    logic [7:0] img[64];

    task automatic start_load();
        load_start = 1;
        @(negedge clk);
        load_start = 0;
    endtask

    // density < 0 means in_valid alternates every cycle
    task automatic stream(input int n, input int last_idx, input int density, input bit noise,
                          output int acc);
        int idx = 0;
        bit a;
        for (int c = 0; c < n * 8 + 40 && idx < n; c++) begin
            in_valid   = density < 0 ? (c % 2 == 0) : ($urandom_range(99) < density);
            in_data    = img[idx];
            in_last    = idx == last_idx;
            load_start = noise && $urandom_range(7) == 0;
            a = in_valid && in_ready;
            @(negedge clk);
            if (a) idx++;
        end
        in_valid = 0; in_last = 0; load_start = 0;
        acc = idx;
    endtask

    task automatic wait_end(input string n);
        int c = 0;
        while (!(done || timeout) && c < TO + RH + 100) begin
            @(negedge clk);
            c++;
        end
        chk(n, int'(done || timeout), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        logic [7:0] p3[17] = '{8'hBB, 8'h7C, 8'h9D, 8'h5E, 8'h20, 8'hDF, 8'hF0, 8'hE0, 8'hE0,
                               8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'h00};
        repeat (3) @(negedge clk);
        chk("rst_cpu_rst", int'(cpu_rst), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(in_ready), 0);
        rst = 0;
        @(negedge clk);

        // three-byte image
        img[0] = 8'hE0; img[1] = 8'h01; img[2] = 8'h1F;
        halt_en = 1; halt_at = 5; wq.delete();
        start_load();
        stream(3, 2, 100, 0, acc);
        chk("t1_accepted", acc, 3);
        chk("t1_ready_after_last", int'(in_ready), 0);
        wait_end("t1_end");
        chk("t1_writes", wq.size(), 3);
        if (wq.size() == 3) begin
            chk("t1_w0", wq[0], 'h0E0);
            chk("t1_w1", wq[1], 'h101);
            chk("t1_w2", wq[2], 'h21F);
        end
        chk("t1_release_delay", t_fall - t_we, 5);
        chk("t1_pc", int'(result_pc), 5);

        // program 3 image, HLT at 0x10
        for (int i = 0; i < 17; i++) img[i] = p3[i];
        halt_at = 16; wq.delete();
        start_load();
        stream(17, 16, 100, 0, acc);
        wait_end("t2_end");
        chk("t2_writes", wq.size(), 17);
        chk("t2_done", int'(done), 1);
        chk("t2_pc", int'(result_pc), 'h10);
        chk("t2_timeout", int'(timeout), 0);
        chk("t2_cpu_rst", int'(cpu_rst), 0);

        // 40 bytes with no last marker: only the 32 addresses are written
        for (int i = 0; i < 40; i++) img[i] = 8'($urandom);
        halt_at = 3; wq.delete();
        start_load();
        stream(40, -1, 100, 0, acc);
        chk("t3_accepted", acc, 32);
        chk("t3_writes", wq.size(), 32);
        for (int i = 0; i < wq.size(); i++) chk("t3_addr", wq[i] >> 8, i);
        wait_end("t3_end");

        // CPU never halts
        halt_en = 0;
        start_load();
        stream(4, 3, 100, 0, acc);
        wait_end("t4_end");
        chk("t4_timeout", int'(timeout), 1);
        chk("t4_done", int'(done), 0);
        chk("t4_cpu_rst", int'(cpu_rst), 1);
        chk("t4_run_cycles", t_to - t_fall, 1023);

        // halt on the watchdog expiry cycle
        halt_en = 1; halt_at = TO - 1;
        start_load();
        stream(2, 1, 100, 0, acc);
        wait_end("t6_end");
        chk("t6_done", int'(done), 1);
        chk("t6_timeout", int'(timeout), 0);
        chk("t6_pc", int'(result_pc), 30);

        // sparse stream interrupted by reset, then reload
        wq.delete();
        start_load();
        for (int c = 0; c < 10; c++) begin
            in_valid = c % 2 == 0;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 0;
        @(negedge clk);
        chk("t5_sparse_writes", wq.size(), 5);
        rst = 1;
        @(negedge clk);
        chk("t5_rst_cpu_rst", int'(cpu_rst), 1);
        chk("t5_rst_we", int'(mem_we), 0);
        chk("t5_rst_addr", int'(mem_addr), 0);
        chk("t5_rst_data", int'(mem_wdata), 0);
        chk("t5_rst_pc", int'(result_pc), 0);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_done", int'(done), 0);
        rst = 0;
        @(negedge clk);
        halt_at = 2; wq.delete();
        for (int i = 0; i < 3; i++) img[i] = 8'($urandom);
        start_load();
        stream(3, 2, 50, 0, acc);
        wait_end("t5_end");
        if (wq.size() > 0) chk("t5_reload_addr", wq[0] >> 8, 0);

        // randomized loads
        for (int r = 0; r < 10; r++) begin
            int n, li;
            n  = $urandom_range(1, 32);
            li = (n == 32 && $urandom_range(1) == 0) ? -1 : n - 1;
            for (int i = 0; i < n; i++) img[i] = 8'($urandom);
            halt_en = $urandom_range(3) != 0;
            halt_at = $urandom_range(40);
            start_load();
            stream(n, li, $urandom_range(30, 100), 1, acc);
            chk("rnd_accepted", acc, n);
            wait_end("rnd_end");
            repeat ($urandom_range(3)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
